tt_um_bmsce_project_1: RTL and testbench



---
 rtl/tt_um_bmsce_project_1.sv | 82 ++++++++
 tb/tb_tt_um_bmsce_project_1.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_bmsce_project_1.sv
// -----------------------------------------------------------------------------
// tt_um_bmsce_project_1
//
// This is a 2-bit unsigned magnitude comparator in the Tiny Tapeout user tile
// wrapper. It compares A = ui_in[1:0] with B = ui_in[3:2].
//
// Ports:
//   clk      input   1  system clock
//   rst_n    input   1  asynchronous active-low reset
//   ena      input   1  design selected; registered state updates only when 1
//   ui_in    input   8  [1:0]=A, [3:2]=B, [7:4] ignored
//   uio_in   input   8  ignored
//   uo_out   output  8  [0]=GT, [1]=EQ, [2]=LT (combinational),
//                       [5:3]=registered {LT,EQ,GT}, [6]=CHG, [7]=GT_SEEN
//   uio_out  output  8  constant 0
//   uio_oe   output  8  constant 0 (all bidirectional pins are inputs)
//
// Optional feature:
//   COMPARE_REG_OUT_EN - when defined, uo_out[2:0] come from the registered
//   flags (the same flops as uo_out[5:3]) instead of the combinational core.
// -----------------------------------------------------------------------------
module tt_um_bmsce_project_1 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [1:0] op_a;
    logic [1:0] op_b;
    logic [2:0] cmp_flags;
    logic [2:0] flags_q;
    logic       chg_q;
    logic       gt_seen_q;
    logic [2:0] low_flags;

    // The wrapper pins we do not use are folded into a signal the lint tool
    // recognises as deliberately unused.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ui_in[7:4], uio_in};

    assign op_a = ui_in[1:0];
    assign op_b = ui_in[3:2];

    // Flag order is {LT, EQ, GT}, so bit 0 is GT and bit 2 is LT.
    // Exactly one of the three is set for any operand pair.
    assign cmp_flags = {(op_a < op_b), (op_a == op_b), (op_a > op_b)};

    // Registered history. The held flags are all zero only while in reset.
    // That makes the first enabled edge after reset report a change.
    // CHG is a one-cycle pulse. It is cleared on any edge where ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= 3'b000;
            chg_q     <= 1'b0;
            gt_seen_q <= 1'b0;
        end else if (ena) begin
            flags_q <= cmp_flags;
            chg_q   <= (cmp_flags != flags_q);
            if (cmp_flags[0]) begin
                gt_seen_q <= 1'b1;
            end
        end else begin
            chg_q <= 1'b0;
        end
    end

`ifdef COMPARE_REG_OUT_EN
    assign low_flags = flags_q;
`else
    assign low_flags = cmp_flags;
`endif

    assign uo_out  = {gt_seen_q, chg_q, flags_q, low_flags};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_bmsce_project_1.sv
// -----------------------------------------------------------------------------
// tb_tt_um_bmsce_project_1
//
// This is a scoreboard bench for the 2-bit comparator tile. The stimulus side
// drives the inputs and updates a behavioural model. It pushes the expected
// pin values into a queue and then signals the monitor. The monitor samples
// the DUT 1 ns later, then pops and compares every pending entry.
// -----------------------------------------------------------------------------
module tb_tt_um_bmsce_project_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_bmsce_project_1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];
    event       sample_ev;

    // The model state: the last flags captured, the change pulse and the
    // sticky greater-than marker.
    logic [2:0] m_held = 3'b000;
    logic       m_chg = 1'b0;
    logic       m_seen = 1'b0;

    // Compute the flags from the integer values: bit0 = A>B, bit1 = A==B,
    // bit2 = A<B.
    function automatic logic [2:0] flags_of(input int a, input int b);
        logic [2:0] f;
        f[0] = (a > b);
        f[1] = (a == b);
        f[2] = (a < b);
        return f;
    endfunction

    function automatic logic [7:0] expected_out();
        logic [2:0] low;
`ifdef COMPARE_REG_OUT_EN
        low = m_held;
`else
        low = flags_of(int'(ui_in[1:0]), int'(ui_in[3:2]));
`endif
        return {m_seen, m_chg, m_held, low};
    endfunction

    task automatic model_reset();
        m_held = 3'b000;
        m_chg  = 1'b0;
        m_seen = 1'b0;
    endtask

    // Update the model for one rising edge, using the inputs that were
    // stable before that edge.
    task automatic model_edge();
        logic [2:0] f;
        if (!rst_n) begin
            model_reset();
        end else if (ena) begin
            f      = flags_of(int'(ui_in[1:0]), int'(ui_in[3:2]));
            m_chg  = (f != m_held);
            m_held = f;
            if (int'(ui_in[1:0]) > int'(ui_in[3:2])) m_seen = 1'b1;
        end else begin
            m_chg = 1'b0;
        end
    endtask

    task automatic push_check(input string nm);
        exp_q.push_back(expected_out());
        name_q.push_back(nm);
        ->sample_ev;
    endtask

    // Drive one step on the falling edge and check the immediate effect.
    // Then advance the model over the next rising edge and check again.
    task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b,
                                 input logic [3:0] upper, input logic [7:0] uio,
                                 input logic en, input logic rst_val,
                                 input string nm);
        @(negedge clk);
        ui_in  = {upper, b, a};
        uio_in = uio;
        ena    = en;
        rst_n  = rst_val;
        if (!rst_n) model_reset();
        push_check({nm, "_now"});
        @(posedge clk);
        model_edge();
        push_check({nm, "_edge"});
    endtask

    // Assert reset between clock edges. The registered bits must clear
    // without waiting for a clock edge.
    task automatic assertResetMidCycle(input string nm);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        push_check(nm);
    endtask

    task automatic checkOutput(input logic [7:0] exp_uo, input string nm);
        n_checks++;
        if (uo_out === exp_uo) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: uo_out got %b expected %b (ui_in=%h ena=%b rst_n=%b) at %0t",
                     nm, uo_out, exp_uo, ui_in, ena, rst_n, $time);
        end
        n_checks++;
        if ({uio_out, uio_oe} === 16'h0000) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s_uio: uio_out/uio_oe got %h/%h expected 00/00",
                     nm, uio_out, uio_oe);
        end
    endtask

    // The monitor samples 1 ns after each stimulus event and drains the queue.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            while (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front(), name_q.pop_front());
            end
        end
    end

    // The watchdog ends the run if the stimulus ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] ra;
        logic [1:0] rb;
        int         drain;

        // Hold in reset: the registered bits are zero and the low flags
        // still follow the inputs.
        applyStimulus(2'd2, 2'd1, 4'h0, 8'h00, 1'b1, 1'b0, "reset_hold_gt");
        applyStimulus(2'd0, 2'd3, 4'h0, 8'h00, 1'b1, 1'b0, "reset_hold_lt");

        // Sweep all 16 operand pairs with ena high.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                applyStimulus(a[1:0], b[1:0], 4'h0, 8'h00, 1'b1, 1'b1,
                              $sformatf("sweep_a%0d_b%0d", a, b));
            end
        end

        // Check that the upper and bidirectional inputs have no effect.
        applyStimulus(2'd3, 2'd0, 4'hF, 8'hFF, 1'b1, 1'b1, "isolate_ones");
        applyStimulus(2'd3, 2'd0, 4'h0, 8'h00, 1'b1, 1'b1, "isolate_zeros");

        // With ena low, the held flags stay put and CHG is forced low.
        applyStimulus(2'd3, 2'd1, 4'h0, 8'h00, 1'b1, 1'b1, "ena_load_gt");
        applyStimulus(2'd0, 2'd1, 4'h0, 8'h00, 1'b0, 1'b1, "ena_hold1");
        applyStimulus(2'd0, 2'd1, 4'h0, 8'h00, 1'b0, 1'b1, "ena_hold2");
        applyStimulus(2'd0, 2'd1, 4'h0, 8'h00, 1'b1, 1'b1, "ena_resume");

        // GT_SEEN stays set once any greater-than has been captured.
        applyStimulus(2'd1, 2'd0, 4'h0, 8'h00, 1'b1, 1'b1, "sticky_set");
        applyStimulus(2'd0, 2'd0, 4'h0, 8'h00, 1'b1, 1'b1, "sticky_keep1");
        applyStimulus(2'd0, 2'd0, 4'h0, 8'h00, 1'b1, 1'b1, "sticky_keep2");

        // An asynchronous reset mid-cycle clears the state. It is then
        // released with A=B=2.
        assertResetMidCycle("async_reset");
        applyStimulus(2'd2, 2'd2, 4'h0, 8'h00, 1'b1, 1'b1, "release_first");
        applyStimulus(2'd2, 2'd2, 4'h0, 8'h00, 1'b1, 1'b1, "release_second");

        // Step to A<B to show when the low flags respond.
        applyStimulus(2'd0, 2'd3, 4'h0, 8'h00, 1'b1, 1'b1, "step_lt");

        // Random traffic: ena is mostly high, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            applyStimulus(ra, rb, 4'($urandom), 8'($urandom),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 39) != 0),
                          $sformatf("rand%0d", i));
        end

        // Let the monitor drain, with a bound on the wait.
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("[TB] FAIL drain: pending entries got %0d expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
